// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between instruction fetch (IF)
// and load/store (LS). Load/store has fixed priority over fetch. Each access
// runs IDLE -> *_BUS -> RESP -> IDLE. The pipeline is stalled while a
// request is outstanding.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a bus wait timeout.
// When it fires, the transaction completes with bus_err and zero read data.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_inst,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [63:0]       ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic [63:0]       ls_rdata,
    output logic              ls_done,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [63:0]       bus_wdata,
    output logic [7:0]        bus_wmask,
    input  logic              bus_ready,
    input  logic [63:0]       bus_rdata,
    output logic              cpu_stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_BUS = 2'd1,
        LS_BUS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_r;
    logic   owner_ls_r;   // 1: current transaction belongs to load/store
    logic   addr2_r;      // selects the upper instruction word of the doubleword

    // Pick the 32-bit instruction out of the fetched doubleword.
    function automatic logic [31:0] select_word(input logic [63:0] dword, input logic hi);
        logic [31:0] word;
        if (hi) begin
            word = dword[63:32];
        end else begin
            word = dword[31:0];
        end
        return word;
    endfunction

    // Address bits below the doubleword boundary are not forwarded to the bus.
    logic unused_s;
    assign unused_s = ^{if_addr[1:0], ls_addr[2:0], 32'(TIMEOUT)};

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             bus_err_r;
    assign bus_err = bus_err_r;
`else
    assign bus_err = 1'b0;
`endif

    // Stall while any requester has not yet seen its completion pulse.
    always_comb begin
        cpu_stall = (if_req & ~if_done) | (ls_req & ~ls_done);
    end

    // Transaction state machine with registered bus fields and responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_ls_r <= 1'b0;
            addr2_r    <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= 64'd0;
            bus_wmask  <= 8'd0;
            if_inst    <= 32'd0;
            if_done    <= 1'b0;
            ls_rdata   <= 64'd0;
            ls_done    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_r <= '0;
            bus_err_r  <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (ls_req) begin
                        // Data access belongs to the older instruction: wins ties.
                        state_r    <= LS_BUS;
                        owner_ls_r <= 1'b1;
                        addr2_r    <= 1'b0;
                        bus_valid  <= 1'b1;
                        bus_we     <= ls_we;
                        bus_addr   <= {ls_addr[ADDR_W-1:3], 3'b000};
                        bus_wdata  <= ls_wdata;
                        bus_wmask  <= ls_we ? ls_wmask : 8'd0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_r <= '0;
`endif
                    end else if (if_req) begin
                        state_r    <= IF_BUS;
                        owner_ls_r <= 1'b0;
                        addr2_r    <= if_addr[2];
                        bus_valid  <= 1'b1;
                        bus_we     <= 1'b0;
                        bus_addr   <= {if_addr[ADDR_W-1:3], 3'b000};
                        bus_wdata  <= 64'd0;
                        bus_wmask  <= 8'd0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_r <= '0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_BUS, LS_BUS: begin
                    if (bus_ready) begin
                        state_r   <= RESP;
                        bus_valid <= 1'b0;
                        if (owner_ls_r) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= bus_we ? 64'd0 : bus_rdata;
                        end else begin
                            if_done <= 1'b1;
                            if_inst <= select_word(bus_rdata, addr2_r);
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt_r == CNT_W'(TIMEOUT)) begin
                        // Slave never answered: complete with an error and no data.
                        state_r   <= RESP;
                        bus_valid <= 1'b0;
                        bus_err_r <= 1'b1;
                        if (owner_ls_r) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= 64'd0;
                        end else begin
                            if_done <= 1'b1;
                            if_inst <= 32'd0;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= state_r;
                    end
`endif
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Expected completions are
// queued when a request is driven and compared when if_done/ls_done pulses.
module tb_mem_arbiter;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_inst;
    logic              if_done;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [63:0]       ls_wdata;
    logic [7:0]        ls_wmask;
    logic [63:0]       ls_rdata;
    logic              ls_done;
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic [7:0]        bus_wmask;
    logic              bus_ready;
    logic [63:0]       bus_rdata;
    logic              cpu_stall;
    logic              bus_err;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .cpu_stall(cpu_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ls;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic ls, input logic [63:0] data, input logic err);
        exp_t e;
        e.ls   = ls;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (if_done || ls_done) begin
            exp_t e;
            check_eq("single_done", {62'd0, if_done, ls_done} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("done_owner", {63'd0, ls_done}, {63'd0, e.ls});
                if (e.ls) begin
                    check_eq("ls_rdata", ls_rdata, e.data);
                end else begin
                    check_eq("if_inst", {32'd0, if_inst}, e.data);
                end
                check_eq("bus_err", {63'd0, bus_err}, {63'd0, e.err});
            end
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = 64'd0; ls_wmask = 8'd0; bus_ready = 1'b0; bus_rdata = 64'd0;

        // Reset state
        cyc(); cyc();
        check_eq("rst_valid", {63'd0, bus_valid}, 64'd0);
        check_eq("rst_outs", {59'd0, bus_we, if_done, ls_done, bus_err, cpu_stall}, 64'd0);
        check_eq("rst_addr", bus_addr, 64'd0);
        check_eq("rst_wdata", bus_wdata, 64'd0);
        check_eq("rst_wmask", {56'd0, bus_wmask}, 64'd0);
        check_eq("rst_inst", {32'd0, if_inst}, 64'd0);
        check_eq("rst_rdata", ls_rdata, 64'd0);
        rst = 1'b0;
        cyc();

        // bus_ready with no transaction is ignored
        bus_ready = 1'b1;
        cyc();
        bus_ready = 1'b0;
        check_eq("idle_ready_valid", {63'd0, bus_valid}, 64'd0);
        cyc();
        check_eq("idle_ready_done", {62'd0, if_done, ls_done}, 64'd0);

        // Single fetch, upper word
        if_req = 1'b1; if_addr = 64'h8000_0004;
        push_exp(1'b0, 64'h0050_0093, 1'b0);
        cyc();
        check_eq("f1_valid", {63'd0, bus_valid}, 64'd1);
        check_eq("f1_addr", bus_addr, 64'h8000_0000);
        check_eq("f1_we_mask", {55'd0, bus_we, bus_wmask}, 64'd0);
        check_eq("f1_stall", {63'd0, cpu_stall}, 64'd1);
        bus_ready = 1'b1; bus_rdata = 64'h0050_0093_0000_0013;
        cyc();
        bus_ready = 1'b0;
        check_eq("f1_done_lat", {63'd0, if_done}, 64'd1);
        check_eq("f1_stall_done", {63'd0, cpu_stall}, 64'd0);
        if_req = 1'b0;
        cyc();
        check_eq("f1_pulse", {63'd0, if_done}, 64'd0);
        cyc();

        // Simultaneous store and fetch: store first
        if_req = 1'b1; if_addr = 64'h8000_0100;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1008;
        ls_wmask = 8'h0F; ls_wdata = 64'h0000_0000_DEAD_BEEF;
        push_exp(1'b1, 64'd0, 1'b0);
        push_exp(1'b0, 64'h3333_4444, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            check_eq("s_valid", {63'd0, bus_valid}, 64'd1);
            check_eq("s_we", {63'd0, bus_we}, 64'd1);
            check_eq("s_addr", bus_addr, 64'h8000_1008);
            check_eq("s_wmask", {56'd0, bus_wmask}, 64'h0F);
            check_eq("s_wdata", bus_wdata, 64'h0000_0000_DEAD_BEEF);
            check_eq("s_stall", {63'd0, cpu_stall}, 64'd1);
            cyc();
        end
        bus_ready = 1'b1; bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        cyc();
        bus_ready = 1'b0;
        check_eq("s_done", {62'd0, ls_done, if_done}, 64'd2);
        check_eq("s_stall_resp", {63'd0, cpu_stall}, 64'd1);
        ls_req = 1'b0; ls_we = 1'b0;
        cyc();
        check_eq("s_idle_valid", {63'd0, bus_valid}, 64'd0);
        check_eq("s_idle_stall", {63'd0, cpu_stall}, 64'd1);
        cyc();
        check_eq("sf_valid", {63'd0, bus_valid}, 64'd1);
        check_eq("sf_addr", bus_addr, 64'h8000_0100);
        check_eq("sf_we_mask", {55'd0, bus_we, bus_wmask}, 64'd0);
        bus_ready = 1'b1; bus_rdata = 64'h1111_2222_3333_4444;
        cyc();
        bus_ready = 1'b0;
        check_eq("sf_done", {63'd0, if_done}, 64'd1);
        if_req = 1'b0;
        cyc();

        // Load with wait states and a payload change mid-transaction
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_2010; ls_wmask = 8'hFF;
        push_exp(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        cyc();
        ls_addr = 64'h9000_0000; ls_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("w_addr", bus_addr, 64'h8000_2010);
            check_eq("w_we_mask", {55'd0, bus_we, bus_wmask}, 64'd0);
            check_eq("w_nodone", {63'd0, ls_done}, 64'd0);
            cyc();
        end
        bus_ready = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
        cyc();
        bus_ready = 1'b0;
        check_eq("w_done", {63'd0, ls_done}, 64'd1);
        ls_req = 1'b0; ls_we = 1'b0;
        cyc();
        check_eq("w_pulse", {63'd0, ls_done}, 64'd0);
        cyc();

        // Reset mid-transaction abandons the load
        ls_req = 1'b1; ls_addr = 64'h8000_3000;
        cyc();
        check_eq("r_valid", {63'd0, bus_valid}, 64'd1);
        rst = 1'b1; ls_req = 1'b0;
        cyc();
        check_eq("r_drop", {63'd0, bus_valid}, 64'd0);
        check_eq("r_nodone", {63'd0, ls_done}, 64'd0);
        rst = 1'b0;
        cyc();
        if_req = 1'b1; if_addr = 64'h8000_000C;
        push_exp(1'b0, 64'hCAFE_F00D, 1'b0);
        cyc();
        check_eq("r2_addr", bus_addr, 64'h8000_0008);
        bus_ready = 1'b1; bus_rdata = 64'hCAFE_F00D_1234_5678;
        cyc();
        bus_ready = 1'b0;
        check_eq("r2_done", {63'd0, if_done}, 64'd1);
        if_req = 1'b0;
        cyc(); cyc();

        // Unanswered load: timeout or indefinite wait
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_4000;
`ifdef MEM_ARB_TIMEOUT_EN
        push_exp(1'b1, 64'd0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check_eq("t_wait", {63'd0, ls_done}, 64'd0);
        end
        cyc();
        check_eq("t_done", {63'd0, ls_done}, 64'd1);
        check_eq("t_err", {63'd0, bus_err}, 64'd1);
        check_eq("t_data", ls_rdata, 64'd0);
        ls_req = 1'b0;
        cyc(); cyc();
`else
        for (int i = 1; i <= 100; i++) begin
            cyc();
        end
        check_eq("nt_valid", {63'd0, bus_valid}, 64'd1);
        check_eq("nt_nodone", {62'd0, ls_done, bus_err}, 64'd0);
        check_eq("nt_stall", {63'd0, cpu_stall}, 64'd1);
        rst = 1'b1; ls_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
`endif

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
